// File: rtl/map_mod_pkg.sv
// Shared constants and helper functions for the streaming constellation mapper.
// Covers mode encoding, bits per symbol, amplitude step sizes and Gray decoding.
package map_mod_pkg;

    localparam logic [2:0] ModBpsk   = 3'd0;
    localparam logic [2:0] ModQpsk   = 3'd1;
    localparam logic [2:0] ModQam16  = 3'd2;
    localparam logic [2:0] ModQam64  = 3'd3;
    localparam logic [2:0] ModQam256 = 3'd4;

    // Codes 5-7 fall back to BPSK.
    function automatic int unsigned bits_per_sym(input logic [2:0] mod);
        case (mod)
            ModQpsk:   return 2;
            ModQam16:  return 4;
            ModQam64:  return 6;
            ModQam256: return 8;
            default:   return 1;
        endcase
    endfunction

    // Outer constellation points stay just inside +/- 2^(data_size-2).
    function automatic int unsigned step_of(input logic [2:0] mod, input int unsigned data_size);
        int unsigned quarter;
        quarter = 32'd1 << (data_size - 2);
        case (mod)
            ModQam16:  return quarter / 3;
            ModQam64:  return quarter / 7;
            ModQam256: return quarter / 15;
            default:   return quarter;
        endcase
    endfunction

    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/map_modulation_stream_if.sv
// Input word stream, mode select and output symbol beat stream of the mapper.
interface map_modulation_stream_if #(
    parameter int unsigned DATA_SIZE = 16,
    parameter int unsigned NUM_SYM   = 8,
    parameter int unsigned IN_WIDTH  = 64
) ();

    logic [2:0]                   mod_sel;
    logic [IN_WIDTH-1:0]          in_data;
    logic                         in_valid;
    logic                         in_last;
    logic                         in_ready;
    logic [NUM_SYM*DATA_SIZE-1:0] out_data_i;
    logic [NUM_SYM*DATA_SIZE-1:0] out_data_q;
    logic                         out_valid;
    logic                         out_last;
    logic                         out_ready;

    modport master (
        output mod_sel, in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data_i, out_data_q, out_valid, out_last
    );

    modport slave (
        input  mod_sel, in_data, in_valid, in_last, out_ready,
        output in_ready, out_data_i, out_data_q, out_valid, out_last
    );

endinterface

// File: rtl/map_mod_point.sv
// Combinational map of one k-bit group to a signed (I,Q) constellation point.
module map_mod_point
    import map_mod_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 16
) (
    input  logic [2:0]                  mod,
    input  logic [7:0]                  bits,
    output logic signed [DATA_SIZE-1:0] sym_i,
    output logic signed [DATA_SIZE-1:0] sym_q
);

    localparam int unsigned W = DATA_SIZE + 4;

    logic [3:0]          f_i;
    logic [3:0]          f_q;
    logic [4:0]          m_max;
    logic                q_zero;
    logic signed [W-1:0] m_i;
    logic signed [W-1:0] m_q;
    logic signed [W-1:0] off;
    logic signed [W-1:0] step_w;

    always_comb begin
        f_i    = {3'b000, bits[0]};
        f_q    = 4'b0000;
        m_max  = 5'd1;
        q_zero = 1'b1;
        case (mod)
            ModQpsk: begin
                f_i    = {3'b000, bits[0]};
                f_q    = {3'b000, bits[1]};
                q_zero = 1'b0;
            end
            ModQam16: begin
                f_i    = {2'b00, bits[1:0]};
                f_q    = {2'b00, bits[3:2]};
                m_max  = 5'd3;
                q_zero = 1'b0;
            end
            ModQam64: begin
                f_i    = {1'b0, bits[2:0]};
                f_q    = {1'b0, bits[5:3]};
                m_max  = 5'd7;
                q_zero = 1'b0;
            end
            ModQam256: begin
                f_i    = bits[3:0];
                f_q    = bits[7:4];
                m_max  = 5'd15;
                q_zero = 1'b0;
            end
            default: begin
                f_i = {3'b000, bits[0]};
            end
        endcase
    end

    // level = (2m - (M-1)) * STEP; the widened width keeps the product exact.
    always_comb begin
        m_i    = $signed({{(W-4){1'b0}}, gray2bin(f_i)});
        m_q    = $signed({{(W-4){1'b0}}, gray2bin(f_q)});
        off    = $signed({{(W-5){1'b0}}, m_max});
        step_w = $signed(W'(step_of(mod, DATA_SIZE)));
        sym_i  = DATA_SIZE'(((m_i + m_i) - off) * step_w);
        sym_q  = q_zero ? '0 : DATA_SIZE'(((m_q + m_q) - off) * step_w);
    end

endmodule

// File: rtl/map_modulation_stream.sv
// Streaming constellation mapper: bit gearbox, per-frame mode latch, frame flush
// with zero padding, and registered symbol beats behind a valid/ready handshake.
module map_modulation_stream
    import map_mod_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 16,
    parameter int unsigned NUM_SYM   = 8,
    parameter int unsigned IN_WIDTH  = 64
) (
    input logic                     clk,
    input logic                     rst,
    map_modulation_stream_if.slave  bus
);

    localparam int unsigned BufW = NUM_SYM * 8 + IN_WIDTH;
    localparam int unsigned CntW = $clog2(BufW + 1);
    localparam int unsigned OutW = NUM_SYM * DATA_SIZE;

    logic [BufW-1:0] buf_q, buf_d, shifted;
    logic [CntW-1:0] cnt_q, cnt_d, base, need;
    logic [2:0]      mod_q;
    logic            flush_q, flush_d;
    logic [OutW-1:0] out_i_q, out_q_q, map_i, map_q;
    logic            out_valid_q, out_last_q;
    logic            in_ready, accept, load, last_now;

    assign in_ready = !rst && !flush_q && (cnt_q <= CntW'(BufW - IN_WIDTH));
    assign accept   = bus.in_valid && in_ready;
    assign need     = CntW'(NUM_SYM * bits_per_sym(mod_q));
    assign load     = (!out_valid_q || bus.out_ready) &&
                      ((cnt_q >= need) || (flush_q && (cnt_q != '0)));

    // Bits above cnt are always zero, so short flush beats are zero padded for free.
    for (genvar s = 0; s < NUM_SYM; s++) begin : g_sym
        logic [7:0] grp;
        always_comb begin
            grp = buf_q[s +: 8];
            case (mod_q)
                ModQpsk:   grp = buf_q[s*2 +: 8];
                ModQam16:  grp = buf_q[s*4 +: 8];
                ModQam64:  grp = buf_q[s*6 +: 8];
                ModQam256: grp = buf_q[s*8 +: 8];
                default:   grp = buf_q[s +: 8];
            endcase
        end

        map_mod_point #(
            .DATA_SIZE(DATA_SIZE)
        ) u_point (
            .mod   (mod_q),
            .bits  (grp),
            .sym_i (map_i[s*DATA_SIZE +: DATA_SIZE]),
            .sym_q (map_q[s*DATA_SIZE +: DATA_SIZE])
        );
    end

    always_comb begin
        shifted  = load ? (buf_q >> need) : buf_q;
        base     = load ? ((cnt_q > need) ? (cnt_q - need) : '0) : cnt_q;
        buf_d    = shifted;
        cnt_d    = base;
        if (accept) begin
            buf_d = shifted | (BufW'(bus.in_data) << base);
            cnt_d = base + CntW'(IN_WIDTH);
        end
        last_now = flush_q && (base == '0);
        flush_d  = flush_q;
        if (load && (base == '0)) flush_d = 1'b0;
        if (accept && bus.in_last) flush_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q       <= '0;
            cnt_q       <= '0;
            mod_q       <= ModBpsk;
            flush_q     <= 1'b0;
            out_i_q     <= '0;
            out_q_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            // Mode is only sampled between frames, so it never changes mid-frame.
            if (cnt_q == '0) mod_q <= bus.mod_sel;
            if (load) begin
                out_i_q     <= map_i;
                out_q_q     <= map_q;
                out_valid_q <= 1'b1;
                out_last_q  <= last_now;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_data_i = out_i_q;
    assign bus.out_data_q = out_q_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;

endmodule

// File: tb/tb_map_modulation_stream.sv
// Directed self-checking bench for map_modulation_stream with hand-derived symbol values.
module tb_map_modulation_stream;

    localparam int DS = 16;
    localparam int NS = 8;
    localparam int IW = 64;
    localparam int OW = NS * DS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    map_modulation_stream_if #(.DATA_SIZE(DS), .NUM_SYM(NS), .IN_WIDTH(IW)) bus ();

    map_modulation_stream #(
        .DATA_SIZE(DS),
        .NUM_SYM  (NS),
        .IN_WIDTH (IW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passes = 0;

    logic [OW-1:0] bi[$];
    logic [OW-1:0] bq[$];
    logic          bl[$];
    int            first_v;
    int            acc_c;
    logic          frame_done;

    function automatic int sym(input logic [OW-1:0] v, input int s);
        logic signed [DS-1:0] x;
        x = v[s*DS +: DS];
        return int'(x);
    endfunction

    // Sends one in_last word and collects beats until out_last or the budget expires.
    task automatic run_frame(input logic [IW-1:0] w, input logic [2:0] m, input int budget);
        bi.delete(); bq.delete(); bl.delete();
        first_v = -1; acc_c = -1; frame_done = 1'b0;
        bus.mod_sel = m; bus.in_data = w; bus.in_last = 1'b1; bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < budget && !frame_done; c++) begin
            if (bus.out_valid) begin
                bi.push_back(bus.out_data_i); bq.push_back(bus.out_data_q);
                bl.push_back(bus.out_last);
                if (first_v < 0) first_v = c;
                if (bus.out_last) frame_done = 1'b1;
            end
            if (bus.in_valid && bus.in_ready && acc_c < 0) acc_c = c;
            @(negedge clk);
            if (acc_c >= 0) begin bus.in_valid = 1'b0; bus.in_last = 1'b0; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.mod_sel = 3'd0; bus.in_data = '0; bus.in_valid = 1'b0;
        bus.in_last = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); else passes++;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); else passes++;
        checks++; if (bus.out_last !== 1'b0) $display("FAIL rst_out_last: got %b want 0", bus.out_last); else passes++;
        checks++; if (bus.out_data_i !== '0) $display("FAIL rst_data_i: got %h want 0", bus.out_data_i); else passes++;
        checks++; if (bus.out_data_q !== '0) $display("FAIL rst_data_q: got %h want 0", bus.out_data_q); else passes++;
        rst = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b want 1", bus.in_ready); else passes++;
        @(negedge clk);
    endtask

    task automatic test_qpsk();
        run_frame(64'h1B, 3'd1, 20);
        checks++; if (frame_done !== 1'b1) $display("FAIL qpsk_done: got %b want 1", frame_done); else passes++;
        checks++; if (bi.size() != 4) $display("FAIL qpsk_beats: got %0d want 4", bi.size()); else passes++;
        // Accept edge is after negedge acc_c; first beat shows at the negedge after the next edge.
        checks++; if (first_v - acc_c != 2) $display("FAIL qpsk_latency: got %0d want 2", first_v - acc_c); else passes++;
        checks++; if (sym(bi[0], 0) != 16384 || sym(bq[0], 0) != 16384) $display("FAIL qpsk_s0: got (%0d,%0d) want (16384,16384)", sym(bi[0], 0), sym(bq[0], 0)); else passes++;
        checks++; if (sym(bi[0], 1) != -16384 || sym(bq[0], 1) != 16384) $display("FAIL qpsk_s1: got (%0d,%0d) want (-16384,16384)", sym(bi[0], 1), sym(bq[0], 1)); else passes++;
        checks++; if (sym(bi[0], 2) != 16384 || sym(bq[0], 2) != -16384) $display("FAIL qpsk_s2: got (%0d,%0d) want (16384,-16384)", sym(bi[0], 2), sym(bq[0], 2)); else passes++;
        checks++; if (sym(bi[0], 3) != -16384 || sym(bq[0], 3) != -16384) $display("FAIL qpsk_s3: got (%0d,%0d) want (-16384,-16384)", sym(bi[0], 3), sym(bq[0], 3)); else passes++;
        checks++; if (sym(bi[0], 7) != -16384 || sym(bq[0], 7) != -16384) $display("FAIL qpsk_s7: got (%0d,%0d) want (-16384,-16384)", sym(bi[0], 7), sym(bq[0], 7)); else passes++;
        checks++; if (bl[0] !== 1'b0 || bl[3] !== 1'b1) $display("FAIL qpsk_last: got %b%b want 01", bl[0], bl[3]); else passes++;
    endtask

    task automatic test_qam16();
        run_frame(64'h2, 3'd2, 20);
        checks++; if (bi.size() != 2) $display("FAIL qam16_beats: got %0d want 2", bi.size()); else passes++;
        // 0b0010: I Gray 10 -> m=3 -> +3*5461, Q Gray 00 -> m=0 -> -3*5461.
        checks++; if (sym(bi[0], 0) != 16383 || sym(bq[0], 0) != -16383) $display("FAIL qam16_s0: got (%0d,%0d) want (16383,-16383)", sym(bi[0], 0), sym(bq[0], 0)); else passes++;
        checks++; if (sym(bi[0], 1) != -16383) $display("FAIL qam16_s1: got %0d want -16383", sym(bi[0], 1)); else passes++;
        checks++; if (bl[1] !== 1'b1) $display("FAIL qam16_last: got %b want 1", bl[1]); else passes++;
    endtask

    task automatic test_qam64_flush();
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL qam64_idle_ready: got %b want 1", bus.in_ready); else passes++;
        bus.mod_sel = 3'd3; bus.in_data = '1; bus.in_last = 1'b1; bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL qam64_ready_t: got %b want 0", bus.in_ready); else passes++;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL qam64_valid_t: got %b want 0", bus.out_valid); else passes++;
        @(negedge clk);
        // All-ones 3-bit Gray field decodes to m=5 -> (10-7)*2340 = 7020.
        checks++; if (bus.out_valid !== 1'b1 || bus.out_last !== 1'b0) $display("FAIL qam64_b1_flags: got v%b l%b want v1 l0", bus.out_valid, bus.out_last); else passes++;
        checks++; if (sym(bus.out_data_i, 0) != 7020 || sym(bus.out_data_q, 7) != 7020) $display("FAIL qam64_b1_sym: got (%0d,%0d) want (7020,7020)", sym(bus.out_data_i, 0), sym(bus.out_data_q, 7)); else passes++;
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL qam64_ready_t1: got %b want 0", bus.in_ready); else passes++;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_last !== 1'b1) $display("FAIL qam64_b2_flags: got v%b l%b want v1 l1", bus.out_valid, bus.out_last); else passes++;
        checks++; if (sym(bus.out_data_i, 1) != 7020 || sym(bus.out_data_i, 2) != 7020) $display("FAIL qam64_b2_full: got (%0d,%0d) want (7020,7020)", sym(bus.out_data_i, 1), sym(bus.out_data_i, 2)); else passes++;
        // Symbol 2 Q field is {0,0,1} after padding -> m=1 -> (2-7)*2340.
        checks++; if (sym(bus.out_data_q, 2) != -11700) $display("FAIL qam64_b2_s2q: got %0d want -11700", sym(bus.out_data_q, 2)); else passes++;
        checks++; if (sym(bus.out_data_q, 3) != -16380 || sym(bus.out_data_i, 7) != -16380) $display("FAIL qam64_b2_pad: got (%0d,%0d) want (-16380,-16380)", sym(bus.out_data_q, 3), sym(bus.out_data_i, 7)); else passes++;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL qam64_ready_t2: got %b want 1", bus.in_ready); else passes++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [IW-1:0]   w[3];
        logic [3*IW-1:0] stream;
        logic [OW-1:0]   held;
        logic [OW-1:0]   exp_i;
        int              widx;
        w[0] = 64'h0123_4567_89AB_CDEF;
        w[1] = 64'hFEDC_BA98_7654_3210;
        w[2] = 64'hA5A5_5A5A_F0F0_0F0F;
        stream = {w[2], w[1], w[0]};
        bi.delete(); bq.delete(); bl.delete();
        widx = 0; held = '0;
        bus.mod_sel = 3'd0;
        for (int c = 0; c < 150 && bi.size() < 24; c++) begin
            if (c == 2) begin
                held = bus.out_data_i;
                checks++; if (bus.in_ready !== 1'b0) $display("FAIL bpsk_stall: got %b want 0", bus.in_ready); else passes++;
            end
            if (c == 21) begin
                checks++; if (bus.out_valid !== 1'b1) $display("FAIL bpsk_hold_valid: got %b want 1", bus.out_valid); else passes++;
                checks++; if (bus.out_data_i !== held) $display("FAIL bpsk_hold_data: got %h want %h", bus.out_data_i, held); else passes++;
                checks++; if (widx != 2) $display("FAIL bpsk_words_taken: got %0d want 2", widx); else passes++;
            end
            bus.out_ready = (c >= 22);
            if (bus.out_valid && bus.out_ready) begin
                bi.push_back(bus.out_data_i); bq.push_back(bus.out_data_q);
                bl.push_back(bus.out_last);
            end
            if (widx < 3) begin
                bus.in_valid = 1'b1; bus.in_data = w[widx]; bus.in_last = (widx == 2);
                if (bus.in_ready) widx++;
            end else begin
                bus.in_valid = 1'b0; bus.in_last = 1'b0;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
        checks++; if (bi.size() != 24) $display("FAIL bpsk_beats: got %0d want 24", bi.size()); else passes++;
        for (int j = 0; j < bi.size(); j++) begin
            for (int s = 0; s < NS; s++) begin
                exp_i[s*DS +: DS] = stream[j*NS + s] ? 16'sd16384 : -16'sd16384;
            end
            checks++; if (bi[j] !== exp_i) $display("FAIL bpsk_beat%0d_i: got %h want %h", j, bi[j], exp_i); else passes++;
            checks++; if (bq[j] !== '0) $display("FAIL bpsk_beat%0d_q: got %h want 0", j, bq[j]); else passes++;
        end
        checks++; if (bl[23] !== 1'b1 || bl[22] !== 1'b0) $display("FAIL bpsk_last: got %b%b want 01", bl[22], bl[23]); else passes++;
        @(negedge clk);
    endtask

    task automatic test_mod_switch();
        bus.mod_sel = 3'd4; bus.in_data = 64'h08F0; bus.in_last = 1'b1; bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        bus.mod_sel = 3'd1;
        @(negedge clk);
        // 0xF0: I nibble 0 -> -15*1092, Q nibble F -> m=10 -> +5*1092; 0x08: I 8 -> m=15.
        checks++; if (bus.out_valid !== 1'b1 || bus.out_last !== 1'b1) $display("FAIL sw_flags: got v%b l%b want v1 l1", bus.out_valid, bus.out_last); else passes++;
        checks++; if (sym(bus.out_data_i, 0) != -16380 || sym(bus.out_data_q, 0) != 5460) $display("FAIL sw_s0: got (%0d,%0d) want (-16380,5460)", sym(bus.out_data_i, 0), sym(bus.out_data_q, 0)); else passes++;
        checks++; if (sym(bus.out_data_i, 1) != 16380 || sym(bus.out_data_q, 1) != -16380) $display("FAIL sw_s1: got (%0d,%0d) want (16380,-16380)", sym(bus.out_data_i, 1), sym(bus.out_data_q, 1)); else passes++;
        @(negedge clk);
        run_frame(64'h1B, 3'd1, 20);
        checks++; if (bi.size() != 4) $display("FAIL sw_qpsk_beats: got %0d want 4", bi.size()); else passes++;
        checks++; if (sym(bi[0], 0) != 16384 || sym(bq[0], 1) != 16384) $display("FAIL sw_qpsk_sym: got (%0d,%0d) want (16384,16384)", sym(bi[0], 0), sym(bq[0], 1)); else passes++;
    endtask

    task automatic test_reset_midframe();
        bus.mod_sel = 3'd3; bus.in_data = '1; bus.in_last = 1'b0; bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1) $display("FAIL rmid_pending: got %b want 1", bus.out_valid); else passes++;
        rst = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL rmid_in_ready: got %b want 0", bus.in_ready); else passes++;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL rmid_out_valid: got %b want 0", bus.out_valid); else passes++;
        rst = 1'b0;
        run_frame(64'h1B, 3'd1, 20);
        checks++; if (bi.size() != 4) $display("FAIL rmid_beats: got %0d want 4", bi.size()); else passes++;
        checks++; if (sym(bi[0], 0) != 16384 || sym(bq[0], 0) != 16384) $display("FAIL rmid_s0: got (%0d,%0d) want (16384,16384)", sym(bi[0], 0), sym(bq[0], 0)); else passes++;
        checks++; if (sym(bi[0], 1) != -16384 || sym(bq[0], 1) != 16384) $display("FAIL rmid_s1: got (%0d,%0d) want (-16384,16384)", sym(bi[0], 1), sym(bq[0], 1)); else passes++;
    endtask

    initial begin
        test_reset();
        test_qpsk();
        test_qam16();
        test_qam64_flush();
        test_back_to_back();
        test_mod_switch();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
